// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// uart_rx_fifo: receive-side byte FIFO sitting directly behind the UART receiver.
// Captures bytes on the new_data/ack handshake into a power-of-two circular
// buffer and presents them show-ahead with level, full and sticky overrun.
// Optional feature macro: UART_RX_FIFO_WATERMARK_EN adds parameter WATERMARK
// and a registered level-threshold output wm_irq.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
`ifdef UART_RX_FIFO_WATERMARK_EN
    parameter int unsigned WATERMARK = DEPTH / 2,
`endif
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_new_data,
    output logic              rx_ack,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_en,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              overrun,
`ifdef UART_RX_FIFO_WATERMARK_EN
    output logic              wm_irq,
`endif
    input  logic              clr_overrun
);

    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_ack;
    logic              r_overrun;

    logic              w_capture;
    logic              w_nonempty;
    logic              w_full;
    logic              w_pop;
    logic              w_write;
    logic              w_drop;

    // Handshake and FIFO control decode; new_data is masked while ack is high
    // so a held byte is captured only once.
    always_comb begin
        w_capture  = rx_new_data & ~r_ack;
        w_nonempty = (r_level != '0);
        w_full     = (r_level == LVL_FULL);
        w_pop      = rd_en & w_nonempty;
        w_write    = w_capture & (~w_full | w_pop);
        w_drop     = w_capture & w_full & ~w_pop;
    end

    // Byte storage; contents survive reset, only pointers are cleared.
    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    // Pointers and occupancy counter; level is kept separately so full and
    // empty never alias when the pointers meet.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_write && !w_pop) begin
                r_level <= r_level + LVL_ONE;
            end else if (w_pop && !w_write) begin
                r_level <= r_level - LVL_ONE;
            end
        end
    end

    // One-cycle acknowledge for every capture, including dropped bytes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_capture;
        end
    end

    // Sticky overrun; a new drop takes priority over a same-cycle clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_WATERMARK_EN
    localparam logic [ADDR_W:0] WM_LVL = (ADDR_W+1)'(WATERMARK);

    logic r_wm;

    // Watermark flag follows the registered level one cycle later.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wm <= 1'b0;
        end else begin
            r_wm <= (r_level >= WM_LVL);
        end
    end

    assign wm_irq = r_wm;
`endif

    assign rx_ack   = r_ack;
    assign rd_data  = r_mem[r_rd_ptr];
    assign rd_valid = w_nonempty;
    assign level    = r_level;
    assign full     = w_full;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo with a receiver model
// that drops new_data on the edge after it sees ack.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        rx_data;
    logic              rx_new_data;
    logic              rx_ack;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              rd_en;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              overrun;
    logic              clr_overrun;
`ifdef UART_RX_FIFO_WATERMARK_EN
    logic              wm_irq;
`endif

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [7:0]        sb [$];

    uart_rx_fifo #(
        .DEPTH(DEPTH)
`ifdef UART_RX_FIFO_WATERMARK_EN
        , .WATERMARK(8)
`endif
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .rx_data     (rx_data),
        .rx_new_data (rx_new_data),
        .rx_ack      (rx_ack),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_en       (rd_en),
        .level       (level),
        .full        (full),
        .overrun     (overrun),
`ifdef UART_RX_FIFO_WATERMARK_EN
        .wm_irq      (wm_irq),
`endif
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    // Receiver model: present a byte, wait (bounded) for ack, release on the next edge.
    task automatic send(input logic [7:0] b);
        bit acked;
        acked       = 1'b0;
        rx_data     = b;
        rx_new_data = 1'b1;
        for (int i = 0; i < 20 && !acked; i++) begin
            @(posedge clk); #1;
            if (rx_ack === 1'b1) acked = 1'b1;
        end
        n_checks++;
        if (!acked) begin
            n_fail++;
            $display("FAIL send_ack: no rx_ack for byte %02h within 20 cycles", b);
        end
        @(posedge clk); #1;
        rx_new_data = 1'b0;
    endtask

    task automatic pop_cycle();
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (rx_ack !== 1'b0 || level !== '0 || rd_valid !== 1'b0 || full !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ack=%b level=%0d valid=%b full=%b ovr=%b, required 0/0/0/0/0",
                     rx_ack, level, rd_valid, full, overrun);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        rx_data     = 8'hA5;
        rx_new_data = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (rx_ack !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 8'hA5 || level !== 5'd1) begin
            n_fail++;
            $display("FAIL single_capture: ack=%b valid=%b data=%02h level=%0d, required 1/1/a5/1",
                     rx_ack, rd_valid, rd_data, level);
        end
        @(posedge clk); #1;
        rx_new_data = 1'b0;
        n_checks++;
        if (rx_ack !== 1'b0 || level !== 5'd1) begin
            n_fail++;
            $display("FAIL single_ack_pulse: ack=%b level=%0d, required 0/1", rx_ack, level);
        end
        pop_cycle();
        n_checks++;
        if (rd_valid !== 1'b0 || level !== '0) begin
            n_fail++;
            $display("FAIL single_pop: valid=%b level=%0d, required 0/0", rd_valid, level);
        end
    endtask

    task automatic test_held_new_data();
        send(8'h3C);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (level !== 5'd1 || rd_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL held_no_dup: level=%0d data=%02h, required 1/3c", level, rd_data);
        end
        pop_cycle();
    endtask

    task automatic test_fill_overrun();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            send(8'(i));
            sb.push_back(8'(i));
        end
        n_checks++;
        if (full !== 1'b1 || level !== 5'd16 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: full=%b level=%0d ovr=%b, required 1/16/0", full, level, overrun);
        end
        send(8'h10);
        n_checks++;
        if (overrun !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: ovr=%b level=%0d full=%b, required 1/16/1", overrun, level, full);
        end
        for (int i = 0; i < 16; i++) begin
            exp = sb.pop_front();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                n_fail++;
                $display("FAIL fill_drain[%0d]: valid=%b data=%02h, required 1/%02h", i, rd_valid, rd_data, exp);
            end
            pop_cycle();
        end
        n_checks++;
        if (rd_valid !== 1'b0 || level !== '0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_empty: valid=%b level=%0d ovr=%b, required 0/0/1", rd_valid, level, overrun);
        end
        clr_overrun = 1'b1;
        @(posedge clk); #1;
        clr_overrun = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: ovr=%b, required 0", overrun);
        end
    endtask

    task automatic test_full_simultaneous();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            send(8'(8'h20 + i));
            sb.push_back(8'(8'h20 + i));
        end
        exp = sb.pop_front();
        n_checks++;
        if (rd_data !== exp) begin
            n_fail++;
            $display("FAIL simul_head: data=%02h, required %02h", rd_data, exp);
        end
        sb.push_back(8'h55);
        rx_data     = 8'h55;
        rx_new_data = 1'b1;
        rd_en       = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        n_checks++;
        if (rx_ack !== 1'b1 || level !== 5'd16 || overrun !== 1'b0 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_full: ack=%b level=%0d ovr=%b full=%b, required 1/16/0/1",
                     rx_ack, level, overrun, full);
        end
        @(posedge clk); #1;
        rx_new_data = 1'b0;
        // Drop and clear on the same edge: the set must win.
        rx_data     = 8'h66;
        rx_new_data = 1'b1;
        clr_overrun = 1'b1;
        @(posedge clk); #1;
        clr_overrun = 1'b0;
        n_checks++;
        if (rx_ack !== 1'b1 || overrun !== 1'b1 || level !== 5'd16) begin
            n_fail++;
            $display("FAIL set_beats_clear: ack=%b ovr=%b level=%0d, required 1/1/16", rx_ack, overrun, level);
        end
        @(posedge clk); #1;
        rx_new_data = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp = sb.pop_front();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                n_fail++;
                $display("FAIL simul_drain[%0d]: valid=%b data=%02h, required 1/%02h", i, rd_valid, rd_data, exp);
            end
            pop_cycle();
        end
        n_checks++;
        if (rd_valid !== 1'b0 || level !== '0) begin
            n_fail++;
            $display("FAIL simul_empty: valid=%b level=%0d, required 0/0", rd_valid, level);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp;
        for (int i = 0; i < 40; i++) begin
            send(8'(8'h80 + i));
            sb.push_back(8'(8'h80 + i));
            n_checks++;
            if (level !== 5'(sb.size())) begin
                n_fail++;
                $display("FAIL wrap_level[%0d]: level=%0d, required %0d", i, level, sb.size());
            end
            if (sb.size() == 3) begin
                exp = sb.pop_front();
                n_checks++;
                if (rd_valid !== 1'b1 || rd_data !== exp) begin
                    n_fail++;
                    $display("FAIL wrap_pop[%0d]: valid=%b data=%02h, required 1/%02h", i, rd_valid, rd_data, exp);
                end
                pop_cycle();
            end
        end
        while (sb.size() != 0) begin
            exp = sb.pop_front();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                n_fail++;
                $display("FAIL wrap_tail: valid=%b data=%02h, required 1/%02h", rd_valid, rd_data, exp);
            end
            pop_cycle();
        end
        n_checks++;
        if (level !== '0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_empty: level=%0d valid=%b, required 0/0", level, rd_valid);
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 4; i++) send(8'(8'h40 + i));
        rx_data     = 8'hC5;
        rx_new_data = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (rx_ack !== 1'b1 || level !== 5'd5 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_pre: ack=%b level=%0d ovr=%b, required 1/5/1", rx_ack, level, overrun);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (rx_ack !== 1'b0 || level !== '0 || rd_valid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset: ack=%b level=%0d valid=%b ovr=%b, required 0/0/0/0",
                     rx_ack, level, rd_valid, overrun);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (rx_ack !== 1'b1 || level !== 5'd1 || rd_data !== 8'hC5) begin
            n_fail++;
            $display("FAIL midop_recapture: ack=%b level=%0d data=%02h, required 1/1/c5", rx_ack, level, rd_data);
        end
        @(posedge clk); #1;
        rx_new_data = 1'b0;
        pop_cycle();
        n_checks++;
        if (level !== '0) begin
            n_fail++;
            $display("FAIL midop_drain: level=%0d, required 0", level);
        end
    endtask

`ifdef UART_RX_FIFO_WATERMARK_EN
    task automatic test_watermark();
        for (int i = 0; i < 7; i++) send(8'(i));
        n_checks++;
        if (wm_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL wm_below: wm_irq=%b, required 0", wm_irq);
        end
        rx_data     = 8'h07;
        rx_new_data = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (level !== 5'd8 || wm_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL wm_capture8: level=%0d wm_irq=%b, required 8/0", level, wm_irq);
        end
        @(posedge clk); #1;
        rx_new_data = 1'b0;
        n_checks++;
        if (wm_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL wm_rise: wm_irq=%b, required 1", wm_irq);
        end
        pop_cycle();
        n_checks++;
        if (level !== 5'd7 || wm_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL wm_pop7: level=%0d wm_irq=%b, required 7/1", level, wm_irq);
        end
        @(posedge clk); #1;
        n_checks++;
        if (wm_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL wm_fall: wm_irq=%b, required 0", wm_irq);
        end
        repeat (7) pop_cycle();
    endtask
`endif

    initial begin
        rx_data     = 8'h00;
        rx_new_data = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        test_reset();
        test_single();
        test_held_new_data();
        test_fill_overrun();
        test_full_simultaneous();
        test_wrap();
        test_reset_midop();
`ifdef UART_RX_FIFO_WATERMARK_EN
        test_watermark();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer placed directly downstream of the UART receiver.
- Consumes each byte the receiver presents on its data/new_data/ack handshake and stores it in a power-of-two circular FIFO.
- Presents the stored bytes show-ahead to the CPU-side peripheral logic, with level, full/empty and sticky overrun status.
- Lets software drain received bytes in bursts without dropping any between polls.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, 2..256.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  byte from UART receiver; valid while rx_new_data=1.
- rx_new_data  input  1  receiver has a byte pending; held high until it sees ack.
- rx_ack  output  1  registered one-cycle acknowledge back to the receiver.
- rd_data  output  8  head-of-FIFO byte (show-ahead); valid when rd_valid=1.
- rd_valid  output  1  FIFO not empty.
- rd_en  input  1  pop head entry this cycle; ignored when rd_valid=0.
- level  output  ADDR_W+1  current entry count, 0..DEPTH.
- full  output  1  level==DEPTH.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- clr_overrun  input  1  clears overrun.

Behaviour:
- Reset: i_reset asserts asynchronously.
  - Cleared to 0: wr_ptr, rd_ptr, level, rx_ack, overrun.
  - Hence rd_valid=0 and full=0. rd_data is don't-care; memory contents are not cleared.
- Capture rule: write the entry at a rising edge when rx_new_data=1 and rx_ack=0.
  - On that same edge, rx_ack is set to 1 for exactly one cycle, then returns to 0.
  - The receiver clears new_data on the edge where it sees ack=1, so one byte produces exactly one capture.
  - rx_new_data is ignored while rx_ack=1.
- Upstream latency: a byte is visible on rd_data/rd_valid the cycle after the capture edge.
  - Capture at edge N; rd_valid=1 after edge N if the FIFO was empty.
- Full handling: if full=1 at a capture edge and rd_en=0, the byte is discarded.
  - It is still acknowledged (rx_ack pulses); overrun is set to 1.
  - Pointers and level are unchanged.
- Pop: rd_en=1 and rd_valid=1 at an edge advance rd_ptr and decrement level.
  - rd_data shows the next entry in the following cycle.
- Simultaneous capture and pop:
  - level is unchanged; both pointers advance.
  - When full, the write is accepted (the pop frees the slot) and overrun is not set.
  - When empty, rd_en is ignored and the capture proceeds normally (level 0→1).
- Wrap-around: pointers are ADDR_W bits and wrap modulo DEPTH. level is the separate ADDR_W+1-bit counter, 0..DEPTH, never wrapping.
- Overrun flag:
  - overrun set and clr_overrun at the same edge: set wins (overrun stays 1).
  - Otherwise clr_overrun=1 clears it next cycle.
- Reset mid-operation:
  - If reset asserts while rx_ack=1, ack drops immediately.
  - If the receiver still holds rx_new_data after reset release, that byte is captured at the first edge after release.
- All outputs are registered or decoded from registered state. No combinational path from rx_new_data to rx_ack.

Optional Feature:
- Macro: UART_RX_FIFO_WATERMARK_EN.
- When defined:
  - Adds parameter WATERMARK (default DEPTH/2) and output port wm_irq (1 bit).
  - wm_irq is registered: 1 when level >= WATERMARK, else 0, one cycle after level changes; reset 0.
- When undefined: the port and parameter do not exist and no comparator is built.

Test Plan:
- Single byte: drive rx_data=8'hA5 with rx_new_data=1 until ack.
  - rx_ack=1 for exactly 1 cycle.
  - Next cycle: rd_valid=1, rd_data=8'hA5, level=1.
  - rd_en pulse → rd_valid=0, level=0.
- Held new_data: model the receiver, clearing new_data the edge after ack.
  - Exactly one entry is written (level=1); no duplicate.
- Fill and overrun, DEPTH=16: push 0x00..0x0F → full=1, level=16, overrun=0.
  - Push 0x10 → rx_ack pulses, overrun=1, level=16.
  - Drain yields 0x00..0x0F in order; 0x10 is absent.
- Full + simultaneous: with full=1, assert rd_en on the capture edge of 0x55.
  - level stays 16, overrun=0, 0x55 is the last byte drained.
- Wrap: push/pop 40 bytes with an incrementing pattern, keeping level ≤ 3.
  - All 40 are read back in order; level returns to 0.
- Reset mid-op: with level=5 and rx_ack=1, pulse i_reset asynchronously between edges.
  - Immediately: rx_ack=0, level=0, rd_valid=0, overrun=0.
  - A pending rx_new_data is captured on the first edge after release.
  - With UART_RX_FIFO_WATERMARK_EN, WATERMARK=8: wm_irq rises one cycle after the 8th capture and falls one cycle after the pop to 7.
